// File: rtl/sram_mask_pkg.sv
// Shared constants for the SRAM bit-line mask generator: FSM encoding and span size codes.
package sram_mask_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;

  // Size code s selects a span of 2**s bits.
  localparam int SZ_1 = 0;
  localparam int SZ_2 = 1;
  localparam int SZ_4 = 2;
  localparam int SZ_8 = 3;

  function automatic int size_w(input int sel_w);
    return $clog2(sel_w + 2);
  endfunction

endpackage

// File: rtl/sram_bl_mask_gen_if.sv
// Request side and SRAM write-beat side of the mask generator, bundled with master/slave views.
interface sram_bl_mask_gen_if
  import sram_mask_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int ADDR_W = 6
);
  localparam int N      = 2 ** SEL_W;
  localparam int SIZE_W = size_w(SEL_W);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [SEL_W-1:0]  req_off;
  logic [SIZE_W-1:0] req_size;
  logic [N-1:0]      req_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [N-1:0]      out_mask;
  logic [N-1:0]      out_wdata;
  logic              err;

  modport slave (
    input  req_valid, req_addr, req_off, req_size, req_data, out_ready,
    output req_ready, out_valid, out_addr, out_mask, out_wdata, err
  );

  modport master (
    output req_valid, req_addr, req_off, req_size, req_data, out_ready,
    input  req_ready, out_valid, out_addr, out_mask, out_wdata, err
  );

endinterface

// File: rtl/sram_bl_mask_span.sv
// Combinational lane-span decode: both beat masks, split flag and size legality from (off, size).
module sram_bl_mask_span
  import sram_mask_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]            off,
  input  logic [size_w(SEL_W)-1:0]    size,
  output logic [(2**SEL_W)-1:0]       mask0,
  output logic [(2**SEL_W)-1:0]       mask1,
  output logic                        split,
  output logic                        size_ok
);
  localparam int N      = 2 ** SEL_W;
  localparam int SIZE_W = size_w(SEL_W);

  logic [2*N-1:0] ones;
  logic [2*N-1:0] span_mask;

  // The span is laid out across a double-width word so the overflow half is beat 1.
  always_comb begin
    size_ok   = (size <= SIZE_W'(SEL_W));
    ones      = '0;
    if (size_ok) begin
      ones = ((2*N)'(1) << (32'd1 << size)) - (2*N)'(1);
    end
    span_mask = ones << off;
    mask0     = span_mask[N-1:0];
    mask1     = span_mask[2*N-1:N];
    split     = |mask1;
  end

endmodule

// File: rtl/sram_bl_mask_gen.sv
// Turns (addr, off, size, data) writes into one or two masked SRAM beats; 1-cycle accept-to-beat latency.
// Requests stall while a split request's first beat waits; out_ready feeds req_ready combinationally.
module sram_bl_mask_gen
  import sram_mask_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  sram_bl_mask_gen_if.slave  bus
);
  localparam int N = 2 ** SEL_W;

  logic [1:0]        state;
  logic              split_q;
  logic [ADDR_W-1:0] b1_addr;
  logic [N-1:0]      b1_mask;
  logic [N-1:0]      b1_wdata;

  logic [N-1:0]      mask0;
  logic [N-1:0]      mask1;
  logic              split;
  logic              size_ok;
  logic [2*N-1:0]    wide;
  logic              last_beat;
  logic              accept;
  logic              beat_done;

  sram_bl_mask_span #(.SEL_W(SEL_W)) u_span (
    .off     (bus.req_off),
    .size    (bus.req_size),
    .mask0   (mask0),
    .mask1   (mask1),
    .split   (split),
    .size_ok (size_ok)
  );

  // Data shifted into a double-width word; masking with the beat masks clears unused lanes.
  assign wide = {{N{1'b0}}, bus.req_data} << bus.req_off;

  assign bus.out_valid = (state != ST_EMPTY);
  assign last_beat     = (state == ST_BEAT1) | ((state == ST_BEAT0) & !split_q);
  assign bus.req_ready = !bus.out_valid | (bus.out_ready & last_beat);
  assign accept        = bus.req_valid & bus.req_ready;
  assign beat_done     = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_EMPTY;
      split_q       <= 1'b0;
      b1_addr       <= '0;
      b1_mask       <= '0;
      b1_wdata      <= '0;
      bus.out_addr  <= '0;
      bus.out_mask  <= '0;
      bus.out_wdata <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= accept & !size_ok;
      if (accept && size_ok) begin
        state         <= ST_BEAT0;
        split_q       <= split;
        bus.out_addr  <= bus.req_addr;
        bus.out_mask  <= mask0;
        bus.out_wdata <= wide[N-1:0] & mask0;
        b1_addr       <= bus.req_addr + ADDR_W'(1);
        b1_mask       <= mask1;
        b1_wdata      <= wide[2*N-1:N] & mask1;
      end else if (beat_done) begin
        // An illegal request accepted here also lands in this branch: no beat, just drain.
        if (state == ST_BEAT0 && split_q) begin
          state         <= ST_BEAT1;
          bus.out_addr  <= b1_addr;
          bus.out_mask  <= b1_mask;
          bus.out_wdata <= b1_wdata;
        end else begin
          state <= ST_EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bl_mask_gen.sv
// Scoreboard bench for sram_bl_mask_gen: directed corner cases then randomized traffic, bit-level reference model.
module tb_sram_bl_mask_gen;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] mask;
    logic [7:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done = 1'b0;

  beat_t exp_q[$];
  int    err_issue = 0;
  int    err_seen  = 0;
  int    checks    = 0;
  int    failures  = 0;

  sram_bl_mask_gen_if #(.SEL_W(3), .ADDR_W(6)) bus ();

  sram_bl_mask_gen #(.SEL_W(3), .ADDR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: walk each bit of the span; lanes past the word end spill into the next address.
  task automatic model_push(input logic [5:0] a, input logic [2:0] o, input logic [2:0] s,
                            input logic [7:0] d);
    beat_t b0;
    beat_t b1;
    int    span;
    int    pos;
    bit    spill;
    b0.addr  = a;
    b0.mask  = 8'h00;
    b0.wdata = 8'h00;
    b1.addr  = a + 6'd1;
    b1.mask  = 8'h00;
    b1.wdata = 8'h00;
    spill    = 1'b0;
    span     = 1 << s;
    for (int b = 0; b < span; b++) begin
      pos = int'(o) + b;
      if (pos < 8) begin
        b0.mask[pos]  = 1'b1;
        b0.wdata[pos] = d[b];
      end else begin
        b1.mask[pos-8]  = 1'b1;
        b1.wdata[pos-8] = d[b];
        spill           = 1'b1;
      end
    end
    exp_q.push_back(b0);
    if (spill) exp_q.push_back(b1);
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [2:0] o,
                       input logic [2:0] s, input logic [7:0] d, input logic ordy,
                       input logic rst);
    reset         = rst;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_off   = o;
    bus.req_size  = s;
    bus.req_data  = d;
    bus.out_ready = ordy;
    @(negedge clk);
    #1;
    if (!rst && bus.req_valid && bus.req_ready) begin
      if (s <= 3'd3) model_push(a, o, s, d);
      else err_issue++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus
  initial begin : drv
    logic [2:0] sz;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_off   = '0;
    bus.req_size  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Single beat, then split, then address wrap
    drive(1, 6'd5, 3'd3, 3'd2, 8'h0A, 1, 0);
    drive(1, 6'd5, 3'd6, 3'd2, 8'h0F, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 6'd63, 3'd7, 3'd1, 8'h03, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Illegal size consumed with no beat
    drive(1, 6'd9, 3'd1, 3'd4, 8'hFF, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Split request stalled three cycles on its first beat; a new request waits meanwhile
    drive(1, 6'd5, 3'd6, 3'd2, 8'h0F, 0, 0);
    drive(1, 6'd20, 3'd0, 3'd0, 8'h01, 0, 0);
    drive(1, 6'd20, 3'd0, 3'd0, 8'h01, 0, 0);
    drive(1, 6'd20, 3'd0, 3'd0, 8'h01, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Reset while the second beat is presented
    drive(1, 6'd30, 3'd6, 3'd2, 8'h0F, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Back-to-back full-word writes at one per cycle
    for (int i = 0; i < 6; i++) drive(1, 6'(i + 40), 3'd0, 3'd3, 8'($urandom), 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      drive(($urandom_range(0, 9) < 7), 6'($urandom), 3'($urandom), sz, 8'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end

    repeat (4) drive(0, 0, 0, 0, 0, 1, 0);
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin : mon
    logic       hold_vld;
    logic       post_rst;
    logic       exp_err;
    logic       exp_rdy;
    logic [5:0] h_addr;
    logic [7:0] h_mask;
    logic [7:0] h_wdata;
    hold_vld = 1'b0;
    post_rst = 1'b0;
    h_addr   = '0;
    h_mask   = '0;
    h_wdata  = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (reset) begin
        exp_q.delete();
        err_seen = err_issue;
        hold_vld = 1'b0;
        post_rst = 1'b1;
      end else begin
        if (post_rst) begin
          chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
          chk("rst_out_mask", 32'(bus.out_mask), 32'd0);
          chk("rst_out_wdata", 32'(bus.out_wdata), 32'd0);
          post_rst = 1'b0;
        end
        exp_err  = (err_issue != err_seen);
        err_seen = err_issue;
        chk("err", 32'(bus.err), 32'(exp_err));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        exp_rdy = (exp_q.size() == 0) || (bus.out_ready && exp_q.size() == 1);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (hold_vld) begin
          chk("stall_addr", 32'(bus.out_addr), 32'(h_addr));
          chk("stall_mask", 32'(bus.out_mask), 32'(h_mask));
          chk("stall_wdata", 32'(bus.out_wdata), 32'(h_wdata));
        end
        if (bus.out_valid && exp_q.size() != 0) begin
          chk("beat_addr", 32'(bus.out_addr), 32'(exp_q[0].addr));
          chk("beat_mask", 32'(bus.out_mask), 32'(exp_q[0].mask));
          chk("beat_wdata", 32'(bus.out_wdata), 32'(exp_q[0].wdata));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
        hold_vld = bus.out_valid && !bus.out_ready;
        h_addr   = bus.out_addr;
        h_mask   = bus.out_mask;
        h_wdata  = bus.out_wdata;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench did not complete");
  end

endmodule
